// File: rtl/parking_hour_log.sv
`default_nettype none
// ============================================================================
//  Module      : parking_hour_log
//  Description : Lot occupancy tracker with per-work-hour entry log and an
//                end-of-day rush-hour scan.
//                Ports:
//                  clk, reset (async active-low)
//                  car_enter / car_exit      gate pulses
//                  expired_one_hour          timer hour-boundary pulse
//                  work_hour                 current hour index from timer
//                  work_day_expired          sticky end-of-day level
//                  rd_hour / rd_count        registered log read port
//                  occupancy / full / empty  lot status
//                  day_total                 saturating daily entry total
//                  rush_hour / rush_count / rush_valid   scan result
//  Revision    : 1.0  initial release
// ============================================================================
module parking_hour_log #(
    parameter int NUM_SPACES = 3,
    parameter int NUM_HOURS  = 9,
    parameter int CNT_W      = 8,
    localparam int OCC_W     = $clog2(NUM_SPACES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               car_enter,
    input  logic               car_exit,
    input  logic               expired_one_hour,
    input  logic [3:0]         work_hour,
    input  logic               work_day_expired,
    input  logic [3:0]         rd_hour,
    output logic [CNT_W-1:0]   rd_count,
    output logic [OCC_W-1:0]   occupancy,
    output logic               full,
    output logic               empty,
    output logic [CNT_W+3:0]   day_total,
    output logic [3:0]         rush_hour,
    output logic [CNT_W-1:0]   rush_count,
    output logic               rush_valid
);

    localparam logic [1:0]       c_st_count = 2'd0;
    localparam logic [1:0]       c_st_scan  = 2'd1;
    localparam logic [1:0]       c_st_done  = 2'd2;
    localparam logic [3:0]       c_num_hours = 4'(NUM_HOURS);
    localparam logic [3:0]       c_last_idx  = 4'(NUM_HOURS - 1);
    localparam logic [OCC_W-1:0] c_full_occ  = OCC_W'(NUM_SPACES);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_wde_q;
    logic             w_rise;
    logic             w_fall;
    logic             w_log_en;
    logic             w_clear;
    logic             w_scan_start;
    logic             w_scan_step;
    logic             w_scan_finish;

    logic [CNT_W-1:0] r_log [NUM_HOURS];
    logic [CNT_W+3:0] r_day_total;
    logic [OCC_W-1:0] r_occupancy;
    logic [OCC_W-1:0] w_occ_next;
    logic             w_exit_ok;
    logic             w_enter_ok;
    logic             w_hour_ok;

    logic [3:0]       r_idx;
    logic [3:0]       r_best_hour;
    logic [CNT_W-1:0] r_best_cnt;
    logic [CNT_W-1:0] w_scan_val;
    logic             w_take;
    logic [3:0]       w_cand_hour;
    logic [CNT_W-1:0] w_cand_cnt;

    // The hour boundary needs no action here: work_hour only advances the
    // cycle after the pulse, so a coincident entry already lands in the old hour.
    logic w_unused;
    assign w_unused = expired_one_hour;

    // ---------------- occupancy ----------------
    assign full       = (r_occupancy == c_full_occ);
    assign empty      = (r_occupancy == '0);
    assign occupancy  = r_occupancy;
    assign w_exit_ok  = car_exit && !empty;
    // A full lot still admits a car when one leaves on the same cycle.
    assign w_enter_ok = car_enter && (!full || w_exit_ok);

    always_comb begin
        w_occ_next = r_occupancy;
        if (w_enter_ok && !w_exit_ok) begin
            w_occ_next = r_occupancy + OCC_W'(1);
        end else if (!w_enter_ok && w_exit_ok) begin
            w_occ_next = r_occupancy - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occupancy <= '0;
        end else begin
            r_occupancy <= w_occ_next;
        end
    end

    // ---------------- FSM ----------------
    assign w_rise = work_day_expired && !r_wde_q;
    assign w_fall = !work_day_expired && r_wde_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_count;
            r_wde_q <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wde_q <= work_day_expired;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_count: if (w_rise) w_state_next = c_st_scan;
            c_st_scan: begin
                if (w_fall)                   w_state_next = c_st_count;
                else if (r_idx == c_last_idx) w_state_next = c_st_done;
            end
            c_st_done:  if (w_fall) w_state_next = c_st_count;
            default:    w_state_next = c_st_count;
        endcase
    end

    assign w_hour_ok = (work_hour < c_num_hours);

    always_comb begin
        w_log_en      = 1'b0;
        w_clear       = 1'b0;
        w_scan_start  = 1'b0;
        w_scan_step   = 1'b0;
        w_scan_finish = 1'b0;
        case (r_state)
            c_st_count: begin
                w_log_en     = w_enter_ok && w_hour_ok;
                w_scan_start = w_rise;
            end
            c_st_scan: begin
                w_clear       = w_fall;
                w_scan_step   = !w_fall;
                w_scan_finish = !w_fall && (r_idx == c_last_idx);
            end
            c_st_done:  w_clear = w_fall;
            default: ;
        endcase
    end

    // ---------------- entry log ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_HOURS; i++) r_log[i] <= '0;
            r_day_total <= '0;
        end else if (w_clear) begin
            for (int i = 0; i < NUM_HOURS; i++) r_log[i] <= '0;
            r_day_total <= '0;
        end else if (w_log_en) begin
            if (r_log[work_hour] != '1) r_log[work_hour] <= r_log[work_hour] + CNT_W'(1);
            if (r_day_total != '1)      r_day_total <= r_day_total + (CNT_W+4)'(1);
        end
    end

    assign day_total = r_day_total;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count <= '0;
        end else begin
            rd_count <= (rd_hour < c_num_hours) ? r_log[rd_hour] : '0;
        end
    end

    // ---------------- rush-hour scan ----------------
    assign w_scan_val  = (r_idx < c_num_hours) ? r_log[r_idx] : '0;
    // Strict compare keeps the earliest hour on ties.
    assign w_take      = (w_scan_val > r_best_cnt);
    assign w_cand_hour = w_take ? r_idx : r_best_hour;
    assign w_cand_cnt  = w_take ? w_scan_val : r_best_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx       <= '0;
            r_best_hour <= '0;
            r_best_cnt  <= '0;
            rush_hour   <= '0;
            rush_count  <= '0;
            rush_valid  <= 1'b0;
        end else begin
            if (w_scan_start) begin
                r_idx       <= '0;
                r_best_hour <= '0;
                r_best_cnt  <= '0;
            end else if (w_scan_step) begin
                r_idx       <= r_idx + 4'd1;
                r_best_hour <= w_cand_hour;
                r_best_cnt  <= w_cand_cnt;
            end
            if (w_clear) begin
                rush_hour  <= '0;
                rush_count <= '0;
                rush_valid <= 1'b0;
            end else if (w_scan_finish) begin
                rush_hour  <= w_cand_hour;
                rush_count <= w_cand_cnt;
                rush_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
